// File: rtl/ahb_lite_fifo_master_if.sv
// Bus bundle for the FIFO-fed AHB-Lite master.
// Groups the FIFO pop port, the AHB-Lite master signals and the status outputs.
interface ahb_lite_fifo_master_if #(
  parameter int BUS_WIDTH = 32
);
  logic                 fifo_empty;
  logic                 fifo_write;
  logic [2:0]           fifo_size;
  logic [BUS_WIDTH-1:0] fifo_addr;
  logic [BUS_WIDTH-1:0] fifo_data;
  logic                 fifo_rd_en;
  logic [BUS_WIDTH-1:0] HADDR;
  logic                 HWRITE;
  logic [2:0]           HSIZE;
  logic [2:0]           HBURST;
  logic [3:0]           HPROT;
  logic [1:0]           HTRANS;
  logic [BUS_WIDTH-1:0] HWDATA;
  logic                 HREADY;
  logic                 HRESP;
  logic [BUS_WIDTH-1:0] HRDATA;
  logic                 rd_valid;
  logic [BUS_WIDTH-1:0] rd_data;
  logic                 err;
  logic [BUS_WIDTH-1:0] err_addr;
  logic                 busy;

  modport master (
    input  fifo_empty, fifo_write, fifo_size,
    input  fifo_addr, fifo_data,
    output fifo_rd_en,
    output HADDR, HWRITE, HSIZE, HBURST,
    output HPROT, HTRANS, HWDATA,
    input  HREADY, HRESP, HRDATA,
    output rd_valid, rd_data,
    output err, err_addr, busy
  );

  modport slave (
    output fifo_empty, fifo_write, fifo_size,
    output fifo_addr, fifo_data,
    input  fifo_rd_en,
    input  HADDR, HWRITE, HSIZE, HBURST,
    input  HPROT, HTRANS, HWDATA,
    output HREADY, HRESP, HRDATA,
    input  rd_valid, rd_data,
    input  err, err_addr, busy
  );
endinterface

// File: rtl/ahb_lite_fifo_master.sv
// Pops {write,size,addr,data} FIFO entries and issues each as a single
// pipelined AHB-Lite NONSEQ transfer; ports: clk, reset (async high), bus.
module ahb_lite_fifo_master #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  ahb_lite_fifo_master_if.master bus
);

  typedef enum logic {RUN, ERR} state_t;

  state_t               state;
  logic                 a_valid;
  logic                 a_write;
  logic [2:0]           a_size;
  logic [BUS_WIDTH-1:0] a_addr;
  logic [BUS_WIDTH-1:0] a_data;
  logic                 d_valid;
  logic                 d_write;
  logic [BUS_WIDTH-1:0] d_addr;
  logic [BUS_WIDTH-1:0] d_data;
  logic                 err_hold;
  logic                 rd_valid_q;
  logic [BUS_WIDTH-1:0] rd_data_q;
  logic                 err_q;
  logic [BUS_WIDTH-1:0] err_addr_q;
  logic                 pop;

  assign pop = bus.HREADY & ~bus.fifo_empty
             & ~err_hold & (state == RUN);

  assign bus.fifo_rd_en = pop;
  assign bus.HTRANS     = a_valid ? 2'b10 : 2'b00;
  assign bus.HADDR      = a_addr;
  assign bus.HWRITE     = a_write;
  assign bus.HSIZE      = a_size;
  assign bus.HBURST     = 3'b000;
  assign bus.HPROT      = 4'b0011;
  assign bus.HWDATA     = d_data;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.err        = err_q;
  assign bus.err_addr   = err_addr_q;
  assign bus.busy       = a_valid | d_valid | err_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      a_valid    <= 1'b0;
      a_write    <= 1'b0;
      a_size     <= '0;
      a_addr     <= '0;
      a_data     <= '0;
      d_valid    <= 1'b0;
      d_write    <= 1'b0;
      d_addr     <= '0;
      d_data     <= '0;
      err_hold   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      unique case (state)
        RUN: begin
          if (!bus.HREADY) begin
            // First ERROR cycle: cancel the pending address
            // phase but remember it so it can be reissued.
            if (bus.HRESP) begin
              state    <= ERR;
              err_hold <= a_valid;
              a_valid  <= 1'b0;
            end
          end else begin
            d_valid <= a_valid;
            d_write <= a_write;
            d_addr  <= a_addr;
            d_data  <= a_data;
            if (d_valid) begin
              if (bus.HRESP) begin
                err_q      <= 1'b1;
                err_addr_q <= d_addr;
              end else if (!d_write) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= bus.HRDATA;
              end
            end
            a_valid <= pop;
            if (pop) begin
              a_write <= bus.fifo_write;
              a_size  <= bus.fifo_size;
              a_addr  <= bus.fifo_addr;
              a_data  <= bus.fifo_data;
            end
          end
        end
        ERR: begin
          if (bus.HREADY) begin
            err_q      <= 1'b1;
            err_addr_q <= d_addr;
            d_valid    <= 1'b0;
            a_valid    <= err_hold;
            err_hold   <= 1'b0;
            state      <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_fifo_master.sv
// Directed bench for ahb_lite_fifo_master with FIFO model,
// bus checks and a rd_valid/err scoreboard.
module tb_ahb_lite_fifo_master;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ahb_lite_fifo_master_if #(.BUS_WIDTH(32)) bus ();

  ahb_lite_fifo_master #(.BUS_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        w;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    bit          is_err;
    logic [31:0] val;
  } exp_t;

  ent_t fq[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    if (fq.size() == 0) begin
      bus.fifo_empty = 1'b1;
      bus.fifo_write = 1'b0;
      bus.fifo_size  = 3'd0;
      bus.fifo_addr  = 32'h0;
      bus.fifo_data  = 32'h0;
    end else begin
      bus.fifo_empty = 1'b0;
      bus.fifo_write = fq[0].w;
      bus.fifo_size  = fq[0].sz;
      bus.fifo_addr  = fq[0].a;
      bus.fifo_data  = fq[0].d;
    end
  endtask

  task automatic psh(logic w, logic [2:0] sz, logic [31:0] a, logic [31:0] d);
    ent_t e;
    e.w = w; e.sz = sz; e.a = a; e.d = d;
    fq.push_back(e);
    refresh();
  endtask

  task automatic expect_rd(logic [31:0] v);
    exp_t e;
    e.is_err = 1'b0; e.val = v;
    sb.push_back(e);
  endtask

  task automatic expect_err(logic [31:0] v);
    exp_t e;
    e.is_err = 1'b1; e.val = v;
    sb.push_back(e);
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  // FIFO model: pop after the edge where fifo_rd_en was high
  always @(posedge clk) begin
    logic p;
    p = bus.fifo_rd_en;
    #1;
    if (p && !reset && fq.size() != 0) begin
      void'(fq.pop_front());
      refresh();
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rd_valid) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb_rd: unexpected rd_valid data %0h", bus.rd_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_rd_kind", {31'b0, bus.rd_valid & ~e.is_err}, 32'h1);
          chk("sb_rd_data", bus.rd_data, e.val);
        end
      end
      if (bus.err) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb_err: unexpected err addr %0h", bus.err_addr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_err_kind", {31'b0, bus.err & e.is_err}, 32'h1);
          chk("sb_err_addr", bus.err_addr, e.val);
        end
      end
    end
  end

  initial begin
    reset      = 1'b1;
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = 32'h0;
    refresh();
    nx(); nx();
    chk("rst_htrans", {30'b0, bus.HTRANS}, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("rst_haddr", bus.HADDR, 32'h0);
    chk("rst_rden", {31'b0, bus.fifo_rd_en}, 32'h0);
    chk("rst_hburst", {29'b0, bus.HBURST}, 32'h0);
    chk("rst_hprot", {28'b0, bus.HPROT}, 32'h3);
    reset = 1'b0;
    nx();

    // 1: single write
    psh(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    #1 chk("t1_pop", {31'b0, bus.fifo_rd_en}, 32'h1);
    nx();
    chk("t1_htrans", {30'b0, bus.HTRANS}, 32'h2);
    chk("t1_haddr", bus.HADDR, 32'h10);
    chk("t1_hwrite", {31'b0, bus.HWRITE}, 32'h1);
    chk("t1_hsize", {29'b0, bus.HSIZE}, 32'h2);
    chk("t1_rden0", {31'b0, bus.fifo_rd_en}, 32'h0);
    nx();
    chk("t1_hwdata", bus.HWDATA, 32'hDEADBEEF);
    chk("t1_idle", {30'b0, bus.HTRANS}, 32'h0);
    chk("t1_busy", {31'b0, bus.busy}, 32'h1);
    nx();
    chk("t1_done", {31'b0, bus.busy}, 32'h0);

    // 2: read with two wait states
    bus.HRDATA = 32'hBAD0BAD0;
    psh(1'b0, 3'd2, 32'h20, 32'h0);
    nx();
    chk("t2_htrans", {30'b0, bus.HTRANS}, 32'h2);
    chk("t2_haddr", bus.HADDR, 32'h20);
    chk("t2_hwrite", {31'b0, bus.HWRITE}, 32'h0);
    nx();
    bus.HREADY = 1'b0;
    nx();
    chk("t2_w1_haddr", bus.HADDR, 32'h20);
    chk("t2_w1_htrans", {30'b0, bus.HTRANS}, 32'h0);
    chk("t2_w1_busy", {31'b0, bus.busy}, 32'h1);
    nx();
    chk("t2_w2_haddr", bus.HADDR, 32'h20);
    chk("t2_w2_busy", {31'b0, bus.busy}, 32'h1);
    bus.HREADY = 1'b1;
    bus.HRDATA = 32'h12345678;
    expect_rd(32'h12345678);
    nx();
    nx();
    chk("t2_done", {31'b0, bus.busy}, 32'h0);

    // 3: write/read/write back-to-back
    bus.HRDATA = 32'hCAFE0004;
    psh(1'b1, 3'd2, 32'h0, 32'h000000A0);
    psh(1'b0, 3'd2, 32'h4, 32'h0);
    psh(1'b1, 3'd2, 32'h8, 32'h000000A8);
    expect_rd(32'hCAFE0004);
    nx();
    chk("t3_c1_htrans", {30'b0, bus.HTRANS}, 32'h2);
    chk("t3_c1_haddr", bus.HADDR, 32'h0);
    nx();
    chk("t3_c2_htrans", {30'b0, bus.HTRANS}, 32'h2);
    chk("t3_c2_haddr", bus.HADDR, 32'h4);
    chk("t3_c2_hwdata", bus.HWDATA, 32'hA0);
    nx();
    chk("t3_c3_htrans", {30'b0, bus.HTRANS}, 32'h2);
    chk("t3_c3_haddr", bus.HADDR, 32'h8);
    chk("t3_c3_hwrite", {31'b0, bus.HWRITE}, 32'h1);
    nx();
    chk("t3_c4_idle", {30'b0, bus.HTRANS}, 32'h0);
    chk("t3_c4_hwdata", bus.HWDATA, 32'hA8);
    nx();
    chk("t3_done", {31'b0, bus.busy}, 32'h0);

    // 4: write error while read is in address phase
    bus.HRDATA = 32'h44444444;
    psh(1'b1, 3'd2, 32'h40, 32'h4040);
    psh(1'b0, 3'd2, 32'h44, 32'h0);
    nx();
    chk("t4_w_haddr", bus.HADDR, 32'h40);
    nx();
    chk("t4_r_haddr", bus.HADDR, 32'h44);
    chk("t4_r_htrans", {30'b0, bus.HTRANS}, 32'h2);
    bus.HREADY = 1'b0;
    bus.HRESP  = 1'b1;
    nx();
    chk("t4_e2_idle", {30'b0, bus.HTRANS}, 32'h0);
    chk("t4_e2_busy", {31'b0, bus.busy}, 32'h1);
    chk("t4_e2_rden", {31'b0, bus.fifo_rd_en}, 32'h0);
    bus.HREADY = 1'b1;
    expect_err(32'h40);
    nx();
    chk("t4_re_htrans", {30'b0, bus.HTRANS}, 32'h2);
    chk("t4_re_haddr", bus.HADDR, 32'h44);
    chk("t4_re_hwrite", {31'b0, bus.HWRITE}, 32'h0);
    bus.HRESP = 1'b0;
    expect_rd(32'h44444444);
    nx();
    chk("t4_idle", {30'b0, bus.HTRANS}, 32'h0);
    nx();
    nx();
    chk("t4_done", {31'b0, bus.busy}, 32'h0);

    // 5: FIFO empty
    for (int i = 0; i < 10; i++) begin
      nx();
      chk("t5_htrans", {30'b0, bus.HTRANS}, 32'h0);
      chk("t5_rden", {31'b0, bus.fifo_rd_en}, 32'h0);
      chk("t5_busy", {31'b0, bus.busy}, 32'h0);
    end

    // 6: reset during a read wait state
    psh(1'b0, 3'd2, 32'h80, 32'h0);
    nx();
    chk("t6_htrans", {30'b0, bus.HTRANS}, 32'h2);
    nx();
    bus.HREADY = 1'b0;
    nx();
    chk("t6_busy", {31'b0, bus.busy}, 32'h1);
    reset = 1'b1;
    #1;
    chk("t6_rst_htrans", {30'b0, bus.HTRANS}, 32'h0);
    chk("t6_rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("t6_rst_haddr", bus.HADDR, 32'h0);
    chk("t6_rst_hwdata", bus.HWDATA, 32'h0);
    chk("t6_rst_rden", {31'b0, bus.fifo_rd_en}, 32'h0);
    bus.HREADY = 1'b1;
    bus.HRDATA = 32'h80808080;
    nx(); nx();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nx();
      chk("t6_post_htrans", {30'b0, bus.HTRANS}, 32'h0);
      chk("t6_post_busy", {31'b0, bus.busy}, 32'h0);
    end

    chk("sb_drain", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
